// File: rtl/uart_rx_pkg.sv
// Shared definitions for the 8N1 serial receiver.
// State encodings, oversampling constants and the vote helper.
package uart_rx_pkg;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

  localparam int OVERSAMPLE = 16;
  localparam int SAMPLE_MID = 8;

  localparam logic [3:0] SMP_V0   = 4'(SAMPLE_MID - 1);
  localparam logic [3:0] SMP_V1   = 4'(SAMPLE_MID);
  localparam logic [3:0] SMP_V2   = 4'(SAMPLE_MID + 1);
  localparam logic [3:0] SMP_LAST = 4'(OVERSAMPLE - 1);

  function automatic logic maj3(
    input logic a,
    input logic b,
    input logic c
  );
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// 16x oversampling tick generator.
// Counts 0..div_l-1 while enabled; restart clears the phase.
module uart_baud_tick #(
  parameter int DIV_W = 16
) (
  input  logic             clock100,
  input  logic             reset,
  input  logic             restart,
  input  logic             enable,
  input  logic [DIV_W-1:0] div_l,
  output logic             tick
);

  logic [DIV_W-1:0] div_cnt_q;
  logic [DIV_W-1:0] div_cnt_d;

  assign tick = enable && !restart &&
                (div_cnt_q == div_l - DIV_W'(1));

  always_comb begin
    div_cnt_d = div_cnt_q;
    if (restart) begin
      div_cnt_d = '0;
    end else if (enable) begin
      if (tick) begin
        div_cnt_d = '0;
      end else begin
        div_cnt_d = div_cnt_q + DIV_W'(1);
      end
    end
  end

  always_ff @(posedge clock100 or posedge reset) begin
    if (reset) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 serial receiver with 16x oversampling and 3-sample majority vote.
// Emits the byte with a one-cycle valid pulse or a frame-error pulse.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int SYNC_STAGES = 2,
  parameter int DIV_W       = 16
) (
  input  logic                 clock100,
  input  logic                 reset,
  input  logic                 ser_in,
  input  logic [DIV_W-1:0]     baud_div,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_frame_err,
  output logic                 rx_busy
);

  localparam int BCW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_BITS - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   s_prev_q, s_prev_d;
  logic                   s_line;

  rx_state_e              state_q, state_d;
  logic [3:0]             smp_q, smp_d;
  logic [BCW-1:0]         bit_q, bit_d;
  logic [DATA_BITS-1:0]   shreg_q, shreg_d;
  logic                   v7_q, v7_d;
  logic                   v8_q, v8_d;
  logic [DIV_W-1:0]       div_l_q, div_l_d;
  logic [DATA_BITS-1:0]   rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   rx_err_q, rx_err_d;

  logic                   restart;
  logic                   tick;
  logic                   vote;

  assign sync_d   = {sync_q[SYNC_STAGES-2:0], ser_in};
  assign s_line   = sync_q[SYNC_STAGES-1];
  assign s_prev_d = s_line;
  assign vote     = maj3(v7_q, v8_q, s_line);

  uart_baud_tick #(
    .DIV_W (DIV_W)
  ) u_tick (
    .clock100 (clock100),
    .reset    (reset),
    .restart  (restart),
    .enable   (state_q != RX_IDLE),
    .div_l    (div_l_q),
    .tick     (tick)
  );

  always_comb begin
    state_d    = state_q;
    smp_d      = smp_q;
    bit_d      = bit_q;
    shreg_d    = shreg_q;
    v7_d       = v7_q;
    v8_d       = v8_q;
    div_l_d    = div_l_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    rx_err_d   = 1'b0;
    restart    = 1'b0;

    if (tick) begin
      smp_d = smp_q + 4'd1;
      if (smp_q == SMP_V0) v7_d = s_line;
      if (smp_q == SMP_V1) v8_d = s_line;
    end

    unique case (state_q)
      RX_IDLE: begin
        // falling edge only: a held-low break cannot retrigger
        if (s_prev_q && !s_line) begin
          state_d = RX_START;
          restart = 1'b1;
          smp_d   = '0;
          bit_d   = '0;
          div_l_d = (baud_div < DIV_W'(2)) ? DIV_W'(1) : baud_div;
        end
      end
      RX_START: begin
        if (tick) begin
          if (smp_q == SMP_V2 && vote) begin
            state_d = RX_IDLE;
          end else if (smp_q == SMP_LAST) begin
            state_d = RX_DATA;
          end
        end
      end
      RX_DATA: begin
        if (tick) begin
          if (smp_q == SMP_V2) begin
            shreg_d = {vote, shreg_q[DATA_BITS-1:1]};
          end
          if (smp_q == SMP_LAST) begin
            if (bit_q == LAST_BIT) begin
              state_d = RX_STOP;
            end else begin
              bit_d = bit_q + BCW'(1);
            end
          end
        end
      end
      RX_STOP: begin
        // leave mid stop bit so a back-to-back start edge is seen
        if (tick && smp_q == SMP_V2) begin
          state_d = RX_IDLE;
          if (vote) begin
            rx_data_d  = shreg_q;
            rx_valid_d = 1'b1;
          end else begin
            rx_err_d = 1'b1;
          end
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clock100 or posedge reset) begin
    if (reset) begin
      sync_q     <= '1;
      s_prev_q   <= 1'b1;
      state_q    <= RX_IDLE;
      smp_q      <= '0;
      bit_q      <= '0;
      shreg_q    <= '0;
      v7_q       <= 1'b1;
      v8_q       <= 1'b1;
      div_l_q    <= DIV_W'(1);
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_err_q   <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      s_prev_q   <= s_prev_d;
      state_q    <= state_d;
      smp_q      <= smp_d;
      bit_q      <= bit_d;
      shreg_q    <= shreg_d;
      v7_q       <= v7_d;
      v8_q       <= v8_d;
      div_l_q    <= div_l_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_err_q   <= rx_err_d;
    end
  end

  assign rx_data      = rx_data_q;
  assign rx_valid     = rx_valid_q;
  assign rx_frame_err = rx_err_q;
  assign rx_busy      = (state_q != RX_IDLE);

endmodule
